// File: rtl/mdu_pkg.sv
// Shared types and constants for the multi-cycle signed multiply/divide unit.
package mdu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH) + 1;
    localparam int MULT_LAT  = 33;
    localparam int DIV_LAT   = 34;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    // partial < 2*divisor, so a non-negative difference always fits in WIDTH bits
    assign partial = {rem_in, dividend_bit};
    assign diff    = partial - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// MIPS MULT/DIV unit owning HI/LO: radix-2 Booth multiply, restoring divide.
// Optional MDU_UNSIGNED_EN adds is_unsigned for MULTU/DIVU with unchanged latency.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MDU_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mult_start,
    input  logic             div_start,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(ITER) + 1;

    mdu_state_t state_reg, state_next;

    logic [CW-1:0]        cnt_reg;
    logic                 uns_reg;
    // Booth accumulator: {upper (WIDTH+1), multiplier (WIDTH), q_minus1}
    logic [2*WIDTH+1:0]   acc_reg;
    logic [WIDTH:0]       mcand_reg;
    logic [WIDTH-1:0]     rem_reg, quo_reg, dvsr_reg;
    logic                 a_neg_reg, b_neg_reg;
    logic [WIDTH-1:0]     hi_reg, lo_reg;
    logic                 dz_reg;

    logic                 uns_start;
    logic                 a_neg_start, b_neg_start;
    logic                 last_step;
    logic [WIDTH:0]       upper, upper_sum;
    logic [2*WIDTH+1:0]   acc_step;
    logic [WIDTH-1:0]     rem_step;
    logic                 q_step;

`ifdef MDU_UNSIGNED_EN
    assign uns_start = is_unsigned;
`else
    assign uns_start = 1'b0;
`endif

    assign a_neg_start = ~uns_start & a_in[WIDTH-1];
    assign b_neg_start = ~uns_start & b_in[WIDTH-1];
    assign last_step   = (cnt_reg == CW'(ITER - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mult_start)
                    state_next = ST_MULT;
                else if (div_start)
                    state_next = (b_in == '0) ? ST_DONE : ST_DIV;
            end
            ST_MULT: if (last_step) state_next = ST_DONE;
            ST_DIV:  if (last_step) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // One Booth (or plain shift-add when unsigned) step: add/sub then shift right.
    always_comb begin
        upper     = acc_reg[2*WIDTH+1:WIDTH+1];
        upper_sum = upper;
        acc_step  = acc_reg;
        if (uns_reg) begin
            if (acc_reg[1])
                upper_sum = upper + mcand_reg;
            acc_step = {1'b0, upper_sum, acc_reg[WIDTH:1]};
        end else begin
            case (acc_reg[1:0])
                2'b01:   upper_sum = upper + mcand_reg;
                2'b10:   upper_sum = upper - mcand_reg;
                default: upper_sum = upper;
            endcase
            acc_step = {upper_sum[WIDTH], upper_sum, acc_reg[WIDTH:1]};
        end
    end

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (rem_reg),
        .dividend_bit (quo_reg[WIDTH-1]),
        .divisor      (dvsr_reg),
        .rem_out      (rem_step),
        .q_bit        (q_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            uns_reg   <= 1'b0;
            acc_reg   <= '0;
            mcand_reg <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvsr_reg  <= '0;
            a_neg_reg <= 1'b0;
            b_neg_reg <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (mult_start) begin
                        cnt_reg   <= '0;
                        uns_reg   <= uns_start;
                        dz_reg    <= 1'b0;
                        mcand_reg <= {a_neg_start, a_in};
                        acc_reg   <= {{(WIDTH+1){1'b0}}, b_in, 1'b0};
                    end else if (div_start) begin
                        cnt_reg   <= '0;
                        uns_reg   <= uns_start;
                        dz_reg    <= (b_in == '0);
                        a_neg_reg <= a_neg_start;
                        b_neg_reg <= b_neg_start;
                        rem_reg   <= '0;
                        quo_reg   <= a_neg_start ? -a_in : a_in;
                        dvsr_reg  <= b_neg_start ? -b_in : b_in;
                    end
                end
                ST_MULT: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_step) begin
                        hi_reg <= acc_step[2*WIDTH:WIDTH+1];
                        lo_reg <= acc_step[WIDTH:1];
                    end
                end
                ST_DIV: begin
                    rem_reg <= rem_step;
                    quo_reg <= {quo_reg[WIDTH-2:0], q_step};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                ST_FIX: begin
                    // Remainder takes the dividend's sign; quotient negated on sign mismatch
                    hi_reg <= a_neg_reg ? -rem_reg : rem_reg;
                    lo_reg <= (a_neg_reg ^ b_neg_reg) ? -quo_reg : quo_reg;
                end
                default: ;
            endcase
        end
    end

    assign hi_out   = hi_reg;
    assign lo_out   = lo_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign div_zero = dz_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic reference model checked every cycle,
// plus literal expectations for latency, HI/LO and div_zero per transaction.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .mult_start (mult_start),
        .div_start  (div_start),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] model_mult(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // {remainder, quotient}; truncating division, remainder follows the dividend
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Reference model: cycles remaining until back in idle, pending HI/LO result
    int          m_rem;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_dz, p_wr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
            m_dz  <= 1'b0;
            p_wr  <= 1'b0;
            p_hi  <= '0;
            p_lo  <= '0;
        end else if (m_rem == 0) begin
            if (mult_start) begin
                m_rem          <= MULT_LAT;
                m_dz           <= 1'b0;
                {p_hi, p_lo}   <= model_mult(a_in, b_in);
                p_wr           <= 1'b1;
            end else if (div_start) begin
                m_dz <= (b_in == 32'h0);
                if (b_in == 32'h0) begin
                    m_rem <= 1;
                    p_wr  <= 1'b0;
                end else begin
                    m_rem        <= DIV_LAT;
                    {p_hi, p_lo} <= model_div(a_in, b_in);
                    p_wr         <= 1'b1;
                end
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2 && p_wr) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_hi", hi_out, m_hi);
            check("model_lo", lo_out, m_lo);
            check("model_busy", {31'b0, busy}, {31'b0, m_rem != 0});
            check("model_done", {31'b0, done}, {31'b0, m_rem == 1});
            check("model_div_zero", {31'b0, div_zero}, {31'b0, m_dz});
        end
    end

    task automatic run_op(input string name, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input int repulse,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int lat;
        int bc;
        @(negedge clk);
        a_in = a; b_in = b; mult_start = m; div_start = d;
        @(negedge clk);
        mult_start = 1'b0; div_start = 1'b0;
        a_in = $urandom; b_in = $urandom;
        lat = 1;
        bc  = 0;
        while (lat < 200) begin
            if (busy) bc++;
            if (done) break;
            mult_start = (lat == repulse);
            if (lat == repulse) begin
                a_in = 32'h3;
                b_in = 32'h5;
            end
            @(negedge clk);
            lat++;
        end
        mult_start = 1'b0;
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy_cycles"}, bc, exp_lat);
        check({name, "_hi"}, hi_out, exp_hi);
        check({name, "_lo"}, lo_out, exp_lo);
        check({name, "_div_zero"}, {31'b0, div_zero}, {31'b0, exp_dz});
        $display("op %-12s a=%h b=%h latency=%0d hi=%h lo=%h div_zero=%0b",
                 name, a, b, lat, hi_out, lo_out, div_zero);
    endtask

    initial begin
        #3 reset = 1'b0;
        #1;
        check("reset_hi", hi_out, 32'h0);
        check("reset_lo", lo_out, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_div_zero", {31'b0, div_zero}, 32'h0);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul_7_m3",    1, 0, 32'h00000007, 32'hFFFFFFFD, MULT_LAT, 0,  32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("mul_min_min", 1, 0, 32'h80000000, 32'h80000000, MULT_LAT, 10, 32'h40000000, 32'h00000000, 0);
        run_op("div_m7_2",    0, 1, 32'hFFFFFFF9, 32'h00000002, DIV_LAT,  0,  32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div_ovf",     0, 1, 32'h80000000, 32'hFFFFFFFF, DIV_LAT,  0,  32'h00000000, 32'h80000000, 0);
        run_op("mul_hi1_lo2", 1, 0, 32'h00000006, 32'h2AAAAAAB, MULT_LAT, 0,  32'h00000001, 32'h00000002, 0);
        run_op("div_by_zero", 0, 1, 32'h00000005, 32'h00000000, 1,        0,  32'h00000001, 32'h00000002, 1);
        run_op("mul_clr_dz",  1, 0, 32'h00000064, 32'hFFFFFF9C, MULT_LAT, 0,  32'hFFFFFFFF, 32'hFFFFD8F0, 0);
        run_op("div_100_m7",  0, 1, 32'h00000064, 32'hFFFFFFF9, DIV_LAT,  0,  32'h00000002, 32'hFFFFFFF2, 0);
        run_op("div_m100_m7", 0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, DIV_LAT,  0,  32'hFFFFFFFE, 32'h0000000E, 0);

        // Abort a divide partway through with an asynchronous reset
        @(negedge clk);
        a_in = 32'h00001234; b_in = 32'h00000011; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_hi", hi_out, 32'h0);
        check("abort_lo", lo_out, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        $display("op %-12s reset asserted mid-divide hi=%h lo=%h busy=%0b", "abort_div", hi_out, lo_out, busy);
        @(negedge clk);
        reset = 1'b1;

        run_op("both_starts", 1, 1, 32'h00000006, 32'h00000007, MULT_LAT, 0,  32'h00000000, 32'h0000002A, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle signed multiply/divide unit (MIPS MULT/DIV) that owns the HI and LO registers.
- Sits directly upstream of the register-file write-data select: hi_out/lo_out drive its HI and LO inputs (selects 100/101) for MFHI/MFLO.
- Control FSM pulses a start, stalls on busy, and proceeds on done.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, WIDTH, iterations per operation (always equal to WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_in  input  WIDTH  operand A (multiplicand / dividend), sampled on start.
- b_in  input  WIDTH  operand B (multiplier / divisor), sampled on start.
- mult_start  input  1  one-cycle request for signed multiply.
- div_start  input  1  one-cycle request for signed divide.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  last DIV had divisor 0; sticky until the next start.

Behaviour:
- Reset (async, reset=0): state IDLE; hi_out=0, lo_out=0, busy=0, done=0, div_zero=0; all internal iteration state cleared. Takes effect mid-operation; the aborted result is discarded.
- FSM states: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - mult_start=1 -> latch operands, go to MULT, counter=0.
  - else div_start=1 -> latch operands; if b_in=0 go to DONE with div_zero=1, else go to DIV.
  - Both starts asserted together: mult wins.
- Starts are ignored outside IDLE.
- busy=1 in every state except IDLE.
- MULT: radix-2 Booth, one step per cycle, 2*WIDTH-bit accumulator with arithmetic right shift. After ITER steps -> DONE.
- DIV: restoring division on magnitudes |A|, |B|, one quotient bit per cycle. After ITER steps -> FIX.
- FIX (1 cycle): sign correction.
  - Quotient is negated if sign(A)!=sign(B).
  - Remainder is negated if A<0, so the remainder sign follows the dividend.
- DONE (1 cycle): done=1, then IDLE.
- HI/LO write timing: written on the edge entering DONE.
  - MULT: HI=product[63:32], LO=product[31:0].
  - DIV: HI=remainder, LO=quotient.
  - Div-by-zero: HI/LO unchanged.
- Latency from the start sample edge to done high:
  - MULT: 33 cycles.
  - DIV: 34 cycles.
  - Div-by-zero: 1 cycle.
- Overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no flag.
- div_zero clears on any accepted start.
- hi_out/lo_out hold between operations. Operands may change after the start cycle without effect.

Optional Feature:
- Macro: MDU_UNSIGNED_EN.
- Defined: adds input port is_unsigned (1 bit), sampled with the start.
  - When is_unsigned=1, MULTU uses a zero-extended shift-add instead of Booth, and DIVU skips sign handling (FIX still occupies one cycle).
  - Latencies are unchanged.
- Undefined: port absent; all operations are signed.

Decomposition:
- Package mdu_pkg holds:
  - state enum (IDLE, MULT, DIV, FIX, DONE);
  - WIDTH default;
  - counter width = clog2(ITER)+1;
  - MULT_LAT=33, DIV_LAT=34 constants for the bench.
- One natural sub-module: mdu_div_step, a combinational restoring step (partial remainder, divisor -> next partial remainder, quotient bit). The FSM, Booth datapath and HI/LO registers stay in the top module.

Test Plan:
- MULT 7 * -3 (a=0x00000007, b=0xFFFFFFFD) -> done exactly 33 cycles after the start edge; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for 33 cycles.
- MULT 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0x00000000. A mult_start re-pulsed at cycle 10 is ignored, with no change to latency or result.
- DIV -7 / 2 -> done at 34 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV 5 / 0 after a prior MULT leaving HI=0x1, LO=0x2 -> done 1 cycle after start, div_zero=1, HI/LO still 0x1/0x2. div_zero clears on the next mult_start.
- Mid-operation reset: reset low at cycle 10 of a DIV -> immediately hi_out=lo_out=0, busy=0, done=0. After reset release, mult_start and div_start asserted together -> MULT performed.
